// File: rtl/qlf_k4n8_accum.sv
// Registered carry-chain accumulator cell: LOAD/HOLD/ADD/SUB with
// optional input stage, sticky signed overflow and unsigned saturation.
module qlf_k4n8_accum #(
  parameter int               WIDTH = 8,
  parameter int               PIPE  = 0,
  parameter int               SAT   = 0,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] D,
  input  logic             CI,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OV,
  output logic             out_valid
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  logic             x_valid;
  logic [1:0]       x_op;
  logic [WIDTH-1:0] x_d;
  logic             x_ci;

  generate
    if (PIPE != 0) begin : g_pipe
      logic             s_valid;
      logic [1:0]       s_op;
      logic [WIDTH-1:0] s_d;
      logic             s_ci;

      // Input stage; reset drops any captured op.
      always_ff @(posedge C) begin
        if (R) begin
          s_valid <= 1'b0;
          s_op    <= OP_HOLD;
          s_d     <= '0;
          s_ci    <= 1'b0;
        end else if (CE) begin
          s_valid <= in_valid;
          s_op    <= op;
          s_d     <= D;
          s_ci    <= CI;
        end
      end

      assign x_valid = s_valid;
      assign x_op    = s_op;
      assign x_d     = s_d;
      assign x_ci    = s_ci;
    end else begin : g_direct
      assign x_valid = in_valid;
      assign x_op    = op;
      assign x_d     = D;
      assign x_ci    = CI;
    end
  endgenerate

  logic [WIDTH-1:0] dx;
  logic [WIDTH:0]   sum;
  logic             c_msb;
  logic             v;
  logic [WIDTH-1:0] q_arith;

  // Adder column; carry into MSB recovered from the MSB sum bit.
  always_comb begin
    dx      = (x_op == OP_SUB) ? ~x_d : x_d;
    sum     = {1'b0, Q} + {1'b0, dx}
            + {{WIDTH{1'b0}}, x_ci};
    c_msb   = sum[WIDTH-1] ^ Q[WIDTH-1] ^ dx[WIDTH-1];
    v       = c_msb ^ sum[WIDTH];
    q_arith = sum[WIDTH-1:0];
    if (SAT != 0) begin
      if (x_op == OP_ADD && sum[WIDTH])
        q_arith = '1;
      else if (x_op == OP_SUB && !sum[WIDTH])
        q_arith = '0;
    end
  end

  // Accumulator state; CE=0 freezes everything, reset dominates.
  always_ff @(posedge C) begin
    if (R) begin
      Q         <= INIT;
      CO        <= 1'b0;
      OV        <= 1'b0;
      out_valid <= 1'b0;
    end else if (CE) begin
      out_valid <= x_valid;
      if (x_valid) begin
        unique case (x_op)
          OP_HOLD: ;
          OP_LOAD: begin
            Q  <= x_d;
            CO <= 1'b0;
            OV <= 1'b0;
          end
          OP_ADD, OP_SUB: begin
            Q  <= q_arith;
            CO <= sum[WIDTH];
            OV <= OV | v;
          end
        endcase
      end
    end
  end

endmodule
